// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types and constants for the clock divider controller
//
// Contents:
//   clkdiv_state_t  controller FSM state encoding
//   CLKDIV_WIDTH    default width of divide value and counter
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUN,
        ST_PENDING
    } clkdiv_state_t;

    localparam int CLKDIV_WIDTH = 32;

endpackage

// File: rtl/clkdiv_if.sv
// rtl/clkdiv_if.sv - valid/ready configuration port of the clock divider
//
// Signals:
//   cfg_valid  requester has a configuration
//   cfg_ready  divider can accept a configuration
//   cfg_div    requested half-period in clk_in cycles
//   cfg_en     1 = run after applying, 0 = stop after applying
// Modports: master (requester side), slave (divider side)
interface clkdiv_if
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = CLKDIV_WIDTH
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_en;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/clkdiv_core.sv
// rtl/clkdiv_core.sv - loadable half-period counter and output toggle flop
//
// Ports:
//   clk_in, rst  system clock, synchronous active-high reset
//   run          count and toggle when high, hold when low
//   load         restart: counter and clk_out cleared
//   div          half-period in force (must be >= 1)
//   clk_out      divided clock
//   rise, fall   combinational strobes: this cycle ends a low / high phase
module clkdiv_core
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = CLKDIV_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [WIDTH-1:0] div,
    output logic             clk_out,
    output logic             rise,
    output logic             fall
);
    logic [WIDTH-1:0] cnt;
    logic             boundary;

    // div >= 1 is guaranteed by the controller, so div-1 never wraps.
    assign boundary = run && (cnt == div - WIDTH'(1));
    assign rise     = boundary && !clk_out;
    assign fall     = boundary && clk_out;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (boundary) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else if (run) begin
            cnt     <= cnt + WIDTH'(1);
        end
    end
endmodule

// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - runtime-programmable clock divider controller
//
// Ports:
//   clk_in, rst  system clock, synchronous active-high reset
//   cfg          configuration port (clkdiv_if.slave)
//   clk_out      divided clock, period 2*active_div
//   tick         one-cycle pulse in the first high cycle of clk_out
//   busy         controller not stopped
//   active_div   half-period currently in force
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int WIDTH     = CLKDIV_WIDTH,
    parameter int RESET_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    clkdiv_if.slave          cfg,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] active_div
);
    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);

    clkdiv_state_t    state, state_next;
    logic [WIDTH-1:0] pend_div;
    logic             pend_en;
    logic [WIDTH-1:0] cap_div;
    logic             xfer;
    logic             run, load;
    logic             take_active, take_pend, apply_pend;
    logic             rise, fall;

    // A zero divide would make the compare value wrap; treat it as 1.
    assign cap_div       = (cfg.cfg_div == '0) ? WIDTH'(1) : cfg.cfg_div;
    assign cfg.cfg_ready = (state != ST_PENDING);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign busy          = (state != ST_STOPPED);

    clkdiv_core #(.WIDTH(WIDTH)) u_core (
        .clk_in  (clk_in),
        .rst     (rst),
        .run     (run),
        .load    (load),
        .div     (active_div),
        .clk_out (clk_out),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= ST_STOPPED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        run         = 1'b0;
        load        = 1'b0;
        take_active = 1'b0;
        take_pend   = 1'b0;
        apply_pend  = 1'b0;
        case (state)
            ST_STOPPED: begin
                if (xfer) begin
                    take_active = 1'b1;
                    if (cfg.cfg_en) begin
                        load       = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                run = 1'b1;
                // A boundary in this same cycle is handled normally; the new
                // request waits for the next falling boundary in PENDING.
                if (xfer) begin
                    take_pend  = 1'b1;
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                run = 1'b1;
                // The core clears its counter and drives clk_out low at this
                // boundary on its own, so restart and stop look the same here.
                if (fall) begin
                    apply_pend = 1'b1;
                    state_next = pend_en ? ST_RUN : ST_STOPPED;
                end
            end
            default: state_next = ST_STOPPED;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            active_div <= RST_DIV;
            pend_div   <= '0;
            pend_en    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            tick <= rise;
            if (take_active) begin
                active_div <= cap_div;
            end else if (apply_pend) begin
                active_div <= pend_div;
            end
            if (take_pend) begin
                pend_div <= cap_div;
                pend_en  <= cfg.cfg_en;
            end
        end
    end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb/tb_clkdiv_ctrl.sv - self-checking bench for clkdiv_ctrl
module tb_clkdiv_ctrl;
    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        clk_out, tick, busy;
    logic [31:0] active_div;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_q[$];
    bit mon_en = 1'b0;
    int mon_exp;

    clkdiv_if #(.WIDTH(32)) cfg_bus ();

    clkdiv_ctrl #(.WIDTH(32), .RESET_DIV(2)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .cfg        (cfg_bus),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy),
        .active_div (active_div)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Tick scoreboard: expected tick cycles are queued when a start is sent.
    always @(negedge clk_in) begin
        if (!rst && tick) begin
            check("tick_implies_clk_out", clk_out, 1);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("tick_unexpected_at_cycle", cyc, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("tick_cycle", cyc, mon_exp);
                end
            end
        end
    end

    task automatic do_reset();
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = '0;
        cfg_bus.cfg_en    = 1'b0;
        rst = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    // Called at a negedge; presents one request and returns at the next
    // negedge. t is the cycle in which the transfer happened.
    task automatic send(input logic [31:0] div, input logic en, output int t);
        int n = 0;
        while (!cfg_bus.cfg_ready && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check("send_ready_timeout", cfg_bus.cfg_ready, 1);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = div;
        cfg_bus.cfg_en    = en;
        t = cyc;
        @(negedge clk_in);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_clk(input logic val, input int limit);
        int n = 0;
        while (clk_out !== val && n < limit) begin
            @(negedge clk_in);
            n++;
        end
        check("wait_clk_out_timeout", clk_out, val);
    endtask

    typedef struct {
        logic [31:0] div;
        logic [31:0] exp_active;
        int          exp_half;
    } start_vec_t;

    start_vec_t vecs[5];

    initial begin
        int t, r, v, n;
        bit ok;

        vecs[0] = '{div: 32'd3, exp_active: 32'd3, exp_half: 3};
        vecs[1] = '{div: 32'd0, exp_active: 32'd1, exp_half: 1};
        vecs[2] = '{div: 32'd1, exp_active: 32'd1, exp_half: 1};
        vecs[3] = '{div: 32'd5, exp_active: 32'd5, exp_half: 5};
        vecs[4] = '{div: 32'd2, exp_active: 32'd2, exp_half: 2};

        // Reset state
        do_reset();
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_bus.cfg_ready, 1);
        check("rst_active_div", active_div, 2);

        // Start from STOPPED: first rise at t+1+h, ticks every 2h
        foreach (vecs[i]) begin
            do_reset();
            repeat (9) @(negedge clk_in);
            exp_q.delete();
            mon_en = 1'b1;
            send(vecs[i].div, 1'b1, t);
            for (int k = 0; k < 3; k++) exp_q.push_back(t + 1 + (2 * k + 1) * vecs[i].exp_half);
            check("start_active_div", active_div, vecs[i].exp_active);
            check("start_busy", busy, 1);
            check("start_clk_out_low", clk_out, 0);
            n = 0;
            while (cyc < t + 2 + 5 * vecs[i].exp_half && n < 200) begin
                @(negedge clk_in);
                n++;
            end
            check("start_ticks_remaining", exp_q.size(), 0);
            mon_en = 1'b0;
        end

        // Configure while stopped with en=0: divide changes, nothing runs
        do_reset();
        send(32'd9, 1'b0, t);
        check("stopped_cfg_active_div", active_div, 9);
        check("stopped_cfg_busy", busy, 0);
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk_in);
            if (clk_out !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check("stopped_cfg_stays_idle", ok, 1);

        // Change 4 -> 2 at the start of a high phase
        do_reset();
        send(32'd4, 1'b1, t);
        wait_clk(1'b1, 20);
        send(32'd2, 1'b1, r);
        for (int c = 1; c <= 12; c++) begin
            check("chg_clk_out", clk_out, (c < 4) ? 1 : (((c - 4) / 2) % 2));
            if (c <= 3) check("chg_ready_low", cfg_bus.cfg_ready, 0);
            if (c == 4) begin
                check("chg_ready_back", cfg_bus.cfg_ready, 1);
                check("chg_active_div", active_div, 2);
            end
            @(negedge clk_in);
        end

        // Stop at div=5 requested two cycles into a high phase
        do_reset();
        send(32'd5, 1'b1, t);
        wait_clk(1'b1, 20);
        repeat (2) @(negedge clk_in);
        send(32'd5, 1'b0, t);
        for (int c = 0; c < 2; c++) begin
            check("stop_clk_still_high", clk_out, 1);
            check("stop_busy_still_high", busy, 1);
            @(negedge clk_in);
        end
        check("stop_clk_low", clk_out, 0);
        check("stop_busy_low", busy, 0);
        check("stop_ready", cfg_bus.cfg_ready, 1);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk_in);
            if (clk_out !== 1'b0 || tick !== 1'b0) ok = 1'b0;
        end
        check("stop_stays_low", ok, 1);

        // Reset while PENDING at div=7
        do_reset();
        send(32'd7, 1'b1, t);
        wait_clk(1'b1, 30);
        send(32'd3, 1'b1, t);
        check("pend_ready_low", cfg_bus.cfg_ready, 0);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        check("pend_rst_clk_out", clk_out, 0);
        check("pend_rst_active_div", active_div, 2);
        check("pend_rst_ready", cfg_bus.cfg_ready, 1);
        check("pend_rst_busy", busy, 0);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk_in);
            if (clk_out !== 1'b0 || busy !== 1'b0 || active_div !== 32'd2) ok = 1'b0;
        end
        check("pend_rst_discarded", ok, 1);

        // cfg_valid held for 3 cycles in RUN: a single transfer
        do_reset();
        send(32'd4, 1'b1, t);
        repeat (3) @(negedge clk_in);
        check("hold_ready_before", cfg_bus.cfg_ready, 1);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 32'd6;
        cfg_bus.cfg_en    = 1'b1;
        v = cyc;
        @(negedge clk_in);
        check("hold_ready_low_1", cfg_bus.cfg_ready, 0);
        @(negedge clk_in);
        check("hold_ready_low_2", cfg_bus.cfg_ready, 0);
        @(negedge clk_in);
        cfg_bus.cfg_valid = 1'b0;
        n = 0;
        while (!cfg_bus.cfg_ready && n < 12) begin
            @(negedge clk_in);
            n++;
        end
        check("hold_ready_returns", cfg_bus.cfg_ready, 1);
        check("hold_latency_ok", (cyc - v) <= 9, 1);
        check("hold_active_div", active_div, 6);
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk_in);
            if (cfg_bus.cfg_ready !== 1'b1 || active_div !== 32'd6) ok = 1'b0;
        end
        check("hold_single_transfer", ok, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
